// File: rtl/trig_pkg.sv
// Shared definitions for the trigger sequencer: state encodings, CLEAR length
// and the width of a channel index.
package trig_pkg;

    localparam int unsigned STATE_W      = 3;
    localparam int unsigned CH_IDX_W     = 3;
    localparam int unsigned CLEAR_CYCLES = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_HOLD  = 3'd2,
        ST_ARMED = 3'd3,
        ST_POST  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/trig_prio_enc.sv
// Lowest-index-wins priority encoder over the qualified trigger requests.
module trig_prio_enc
    import trig_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]   req,
    output logic [CH_IDX_W-1:0] idx,
    output logic                valid
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = CH_IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trig_sequencer.sv
// Acquisition sequencer for the derivative-trigger channels: flush, holdoff,
// arm, capture the first qualified trigger, post-trigger count, done.
module trig_sequencer
    import trig_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ARM,
    input  logic                ABORT,
    input  logic                AUTO_REARM,
    input  logic                DONE_ACK,
    input  logic [NUM_CH-1:0]   CH_MASK,
    input  logic [CNT_W-1:0]    HOLDOFF,
    input  logic [CNT_W-1:0]    POST_COUNT,
    input  logic [NUM_CH-1:0]   TRIG_IN,
    input  logic [NUM_CH-1:0]   TRIG_EDGE_IN,
    output logic                MOD_ENABLE,
    output logic [NUM_CH-1:0]   CH_ENABLE,
    output logic [STATE_W-1:0]  STATE,
    output logic [CH_IDX_W-1:0] TRIG_CH,
    output logic                TRIG_EDGE,
    output logic [CNT_W-1:0]    TRIG_TS,
    output logic                CAPTURE_DONE,
    output logic                BUSY
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      lim_q, lim_d;
    logic [CNT_W-1:0]      ts_q, ts_d;
    logic [CNT_W-1:0]      trig_ts_q, trig_ts_d;
    logic [CH_IDX_W-1:0]   trig_ch_q, trig_ch_d;
    logic                  trig_edge_q, trig_edge_d;
    logic                  mod_en_q, mod_en_d;
    logic [NUM_CH-1:0]     ch_en_q, ch_en_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic [NUM_CH-1:0]     masked_c;
    logic [NUM_CH-1:0]     win_onehot_c;
    logic [CH_IDX_W-1:0]   win_idx_c;
    logic                  hit_c;
    logic                  win_edge_c;
    logic                  count_done_c;
    logic                  clear_done_c;

    assign masked_c     = TRIG_IN & CH_MASK;
    assign win_onehot_c = masked_c & (~masked_c + NUM_CH'(1));
    assign win_edge_c   = |(TRIG_EDGE_IN & win_onehot_c);

    trig_prio_enc #(
        .NUM_CH (NUM_CH)
    ) u_prio_enc (
        .req   (masked_c),
        .idx   (win_idx_c),
        .valid (hit_c)
    );

    // A limit of zero behaves like one: the state still lasts a single cycle.
    assign count_done_c = (lim_q == '0) || (cnt_q == lim_q - CNT_W'(1));
    assign clear_done_c = (cnt_q == CNT_W'(CLEAR_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lim_d       = lim_q;
        ts_d        = ts_q + CNT_W'(1);
        trig_ts_d   = trig_ts_q;
        trig_ch_d   = trig_ch_q;
        trig_edge_d = trig_edge_q;

        unique case (state_q)
            ST_IDLE: begin
                if (ARM) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (clear_done_c) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    lim_d   = HOLDOFF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (count_done_c) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ARMED: begin
                if (hit_c) begin
                    state_d     = ST_POST;
                    cnt_d       = '0;
                    lim_d       = POST_COUNT;
                    trig_ch_d   = win_idx_c;
                    trig_edge_d = win_edge_c;
                    trig_ts_d   = ts_q;
                end
            end
            ST_POST: begin
                if (count_done_c) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (AUTO_REARM || ARM) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (DONE_ACK) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort wins over everything, including a capture in the same cycle.
        if (ABORT) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            trig_ts_d   = trig_ts_q;
            trig_ch_d   = trig_ch_q;
            trig_edge_d = trig_edge_q;
        end

        mod_en_d = (state_d == ST_HOLD) || (state_d == ST_ARMED) || (state_d == ST_POST);
        ch_en_d  = (state_d == ST_ARMED) ? CH_MASK : '0;
        busy_d   = (state_d == ST_CLEAR) || mod_en_d;
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lim_q       <= '0;
            ts_q        <= '0;
            trig_ts_q   <= '0;
            trig_ch_q   <= '0;
            trig_edge_q <= 1'b0;
            mod_en_q    <= 1'b0;
            ch_en_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lim_q       <= lim_d;
            ts_q        <= ts_d;
            trig_ts_q   <= trig_ts_d;
            trig_ch_q   <= trig_ch_d;
            trig_edge_q <= trig_edge_d;
            mod_en_q    <= mod_en_d;
            ch_en_q     <= ch_en_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign STATE        = state_q;
    assign MOD_ENABLE   = mod_en_q;
    assign CH_ENABLE    = ch_en_q;
    assign TRIG_CH      = trig_ch_q;
    assign TRIG_EDGE    = trig_edge_q;
    assign TRIG_TS      = trig_ts_q;
    assign CAPTURE_DONE = done_q;
    assign BUSY         = busy_q;

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer; captures are checked against a queue of
// expected {channel, edge, timestamp} pushed when each trigger is driven.
module tb_trig_sequencer;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_ARMED = 3'd3;
    localparam logic [2:0] S_POST  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    typedef struct packed {
        logic [2:0]       ch;
        logic             edg;
        logic [CNT_W-1:0] ts;
    } exp_t;

    logic              CLK, RST, ARM, ABORT, AUTO_REARM, DONE_ACK;
    logic [NUM_CH-1:0] CH_MASK, TRIG_IN, TRIG_EDGE_IN;
    logic [CNT_W-1:0]  HOLDOFF, POST_COUNT;
    logic              MOD_ENABLE, TRIG_EDGE, CAPTURE_DONE, BUSY;
    logic [NUM_CH-1:0] CH_ENABLE;
    logic [2:0]        STATE, TRIG_CH;
    logic [CNT_W-1:0]  TRIG_TS;

    int                tests_run    = 0;
    int                tests_failed = 0;
    exp_t              sb[$];
    logic [CNT_W-1:0]  ts_model;
    logic [CNT_W-1:0]  last_ts;
    logic [2:0]        prev_st = 3'd0;

    trig_sequencer #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .ARM          (ARM),
        .ABORT        (ABORT),
        .AUTO_REARM   (AUTO_REARM),
        .DONE_ACK     (DONE_ACK),
        .CH_MASK      (CH_MASK),
        .HOLDOFF      (HOLDOFF),
        .POST_COUNT   (POST_COUNT),
        .TRIG_IN      (TRIG_IN),
        .TRIG_EDGE_IN (TRIG_EDGE_IN),
        .MOD_ENABLE   (MOD_ENABLE),
        .CH_ENABLE    (CH_ENABLE),
        .STATE        (STATE),
        .TRIG_CH      (TRIG_CH),
        .TRIG_EDGE    (TRIG_EDGE),
        .TRIG_TS      (TRIG_TS),
        .CAPTURE_DONE (CAPTURE_DONE),
        .BUSY         (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference free-running timestamp: cycles since reset release, modulo 2^CNT_W.
    always @(posedge CLK or negedge RST) begin
        if (!RST) ts_model <= '0;
        else      ts_model <= ts_model + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic arm_pulse();
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cycles, input string tag);
        int n = 0;
        while (STATE !== st && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, 32'(STATE), 32'(st));
    endtask

    // Capture monitor: every entry into POST must match the oldest expectation.
    always @(posedge CLK) begin
        exp_t e;
        #2;
        if (RST && STATE === S_POST && prev_st !== S_POST) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_capture", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("cap_trig_ch",   32'(TRIG_CH),   32'(e.ch));
                check("cap_trig_edge", 32'(TRIG_EDGE), 32'(e.edg));
                check("cap_trig_ts",   32'(TRIG_TS),   32'(e.ts));
            end
        end
        prev_st = STATE;
    end

    initial begin
        RST = 1'b0; ARM = 1'b0; ABORT = 1'b0; AUTO_REARM = 1'b0; DONE_ACK = 1'b0;
        CH_MASK = 4'hF; TRIG_IN = '0; TRIG_EDGE_IN = '0; HOLDOFF = '0; POST_COUNT = '0;
        tick(); tick();
        check("rst_state", 32'(STATE), 32'(S_IDLE));
        check("rst_mod_en", 32'(MOD_ENABLE), 32'd0);
        check("rst_ch_en", 32'(CH_ENABLE), 32'd0);
        check("rst_trig_ch", 32'(TRIG_CH), 32'd0);
        check("rst_trig_edge", 32'(TRIG_EDGE), 32'd0);
        check("rst_trig_ts", 32'(TRIG_TS), 32'd0);
        check("rst_done", 32'(CAPTURE_DONE), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        RST = 1'b1;
        tick();

        // Nominal capture: holdoff 10, post 5, channel 2 rising
        HOLDOFF = 8'd10; POST_COUNT = 8'd5; CH_MASK = 4'hF;
        arm_pulse();
        check("t1_clear_a", 32'(STATE), 32'(S_CLEAR));
        check("t1_clear_mod", 32'(MOD_ENABLE), 32'd0);
        check("t1_clear_busy", 32'(BUSY), 32'd1);
        tick();
        check("t1_clear_b", 32'(STATE), 32'(S_CLEAR));
        TRIG_IN = 4'b0001; TRIG_EDGE_IN = 4'b0001;
        tick();
        check("t1_hold", 32'(STATE), 32'(S_HOLD));
        check("t1_hold_mod", 32'(MOD_ENABLE), 32'd1);
        check("t1_hold_ch_en", 32'(CH_ENABLE), 32'd0);
        HOLDOFF = 8'd2;
        for (int i = 1; i < 10; i++) begin
            if (i == 4) begin
                TRIG_IN = '0; TRIG_EDGE_IN = '0;
            end
            tick();
            check("t1_hold_len", 32'(STATE), 32'(S_HOLD));
        end
        tick();
        check("t1_armed", 32'(STATE), 32'(S_ARMED));
        check("t1_armed_ch_en", 32'(CH_ENABLE), 32'hF);
        check("t1_armed_mod", 32'(MOD_ENABLE), 32'd1);
        repeat (3) tick();
        check("t1_armed_idle", 32'(STATE), 32'(S_ARMED));
        TRIG_IN = 4'b0100; TRIG_EDGE_IN = 4'b0100;
        sb.push_back('{ch: 3'd2, edg: 1'b1, ts: ts_model});
        tick();
        TRIG_IN = '0; TRIG_EDGE_IN = '0;
        check("t1_post", 32'(STATE), 32'(S_POST));
        check("t1_post_ch_en", 32'(CH_ENABLE), 32'd0);
        check("t1_post_mod", 32'(MOD_ENABLE), 32'd1);
        for (int i = 1; i < 5; i++) begin
            tick();
            check("t1_post_len", 32'(STATE), 32'(S_POST));
        end
        tick();
        check("t1_done", 32'(STATE), 32'(S_DONE));
        check("t1_capture_done", 32'(CAPTURE_DONE), 32'd1);
        check("t1_done_busy", 32'(BUSY), 32'd0);
        check("t1_done_mod", 32'(MOD_ENABLE), 32'd0);
        tick();
        check("t1_done_hold", 32'(STATE), 32'(S_DONE));
        DONE_ACK = 1'b1;
        tick();
        DONE_ACK = 1'b0;
        check("t1_ack_idle", 32'(STATE), 32'(S_IDLE));

        // Zero holdoff/post, simultaneous triggers on ch1 (rising) and ch3 (falling)
        HOLDOFF = 8'd0; POST_COUNT = 8'd0;
        arm_pulse();
        tick();
        tick();
        check("t2_hold", 32'(STATE), 32'(S_HOLD));
        tick();
        check("t2_armed", 32'(STATE), 32'(S_ARMED));
        TRIG_IN = 4'b1010; TRIG_EDGE_IN = 4'b0010;
        sb.push_back('{ch: 3'd1, edg: 1'b1, ts: ts_model});
        tick();
        TRIG_IN = '0; TRIG_EDGE_IN = '0;
        check("t2_post", 32'(STATE), 32'(S_POST));
        tick();
        check("t2_done", 32'(STATE), 32'(S_DONE));
        ARM = 1'b1; DONE_ACK = 1'b1;
        tick();
        ARM = 1'b0; DONE_ACK = 1'b0;
        check("t2_arm_over_ack", 32'(STATE), 32'(S_CLEAR));
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("t2_abort_clear", 32'(STATE), 32'(S_IDLE));

        // Masked channel and empty mask never trigger; ARM ignored while ARMED
        CH_MASK = 4'b0111; HOLDOFF = 8'd3; POST_COUNT = 8'd2;
        arm_pulse();
        wait_state(S_ARMED, 10, "t3_reach_armed");
        TRIG_IN = 4'b1000; TRIG_EDGE_IN = 4'b1000;
        repeat (5) tick();
        check("t3_masked_ignored", 32'(STATE), 32'(S_ARMED));
        check("t3_ch_en", 32'(CH_ENABLE), 32'h7);
        arm_pulse();
        check("t3_arm_ignored", 32'(STATE), 32'(S_ARMED));
        CH_MASK = 4'b0000; TRIG_IN = 4'hF;
        repeat (3) tick();
        check("t3_empty_mask", 32'(STATE), 32'(S_ARMED));
        check("t3_empty_ch_en", 32'(CH_ENABLE), 32'd0);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("t3_abort_armed", 32'(STATE), 32'(S_IDLE));

        // Trigger already high when ARMED is entered fires in the first ARMED cycle
        CH_MASK = 4'hF; TRIG_IN = 4'b0001; TRIG_EDGE_IN = 4'b0000;
        arm_pulse();
        wait_state(S_ARMED, 10, "t3_held_armed");
        sb.push_back('{ch: 3'd0, edg: 1'b0, ts: ts_model});
        tick();
        TRIG_IN = '0;
        check("t3_held_post", 32'(STATE), 32'(S_POST));
        wait_state(S_DONE, 5, "t3_held_done");

        // Auto re-arm: CLEAR for exactly two cycles with modules disabled
        AUTO_REARM = 1'b1;
        tick();
        AUTO_REARM = 1'b0;
        check("t4_rearm_clear_a", 32'(STATE), 32'(S_CLEAR));
        check("t4_rearm_mod_a", 32'(MOD_ENABLE), 32'd0);
        tick();
        check("t4_rearm_clear_b", 32'(STATE), 32'(S_CLEAR));
        check("t4_rearm_mod_b", 32'(MOD_ENABLE), 32'd0);
        tick();
        check("t4_rearm_hold", 32'(STATE), 32'(S_HOLD));
        check("t4_rearm_hold_mod", 32'(MOD_ENABLE), 32'd1);

        // Abort in POST keeps the captured trigger
        POST_COUNT = 8'd20;
        wait_state(S_ARMED, 10, "t4_armed");
        TRIG_IN = 4'b0010; TRIG_EDGE_IN = 4'b0010;
        last_ts = ts_model;
        sb.push_back('{ch: 3'd1, edg: 1'b1, ts: ts_model});
        tick();
        TRIG_IN = '0; TRIG_EDGE_IN = '0;
        check("t4_post", 32'(STATE), 32'(S_POST));
        repeat (3) tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("t4_abort_post", 32'(STATE), 32'(S_IDLE));
        check("t4_abort_mod", 32'(MOD_ENABLE), 32'd0);
        check("t4_abort_busy", 32'(BUSY), 32'd0);
        check("t4_abort_ts_kept", 32'(TRIG_TS), 32'(last_ts));
        check("t4_abort_ch_kept", 32'(TRIG_CH), 32'd1);

        // Asynchronous reset in ARMED clears everything immediately
        arm_pulse();
        wait_state(S_ARMED, 10, "t4_armed_rst");
        RST = 1'b0;
        #1;
        check("t4_rst_state", 32'(STATE), 32'(S_IDLE));
        check("t4_rst_mod", 32'(MOD_ENABLE), 32'd0);
        check("t4_rst_ch_en", 32'(CH_ENABLE), 32'd0);
        check("t4_rst_ts", 32'(TRIG_TS), 32'd0);
        tick();
        RST = 1'b1;
        tick();
        check("t4_post_rst_idle", 32'(STATE), 32'(S_IDLE));

        // Timestamp wrap: trigger a few cycles after the counter rolls over
        HOLDOFF = 8'd2; POST_COUNT = 8'd1;
        arm_pulse();
        wait_state(S_ARMED, 10, "t5_armed");
        begin
            int n = 0;
            while (ts_model != 8'd254 && n < 300) begin
                tick();
                n++;
            end
            check("t5_reach_wrap", 32'(ts_model), 32'd254);
        end
        repeat (4) tick();
        check("t5_still_armed", 32'(STATE), 32'(S_ARMED));
        TRIG_IN = 4'b0001; TRIG_EDGE_IN = 4'b0001;
        sb.push_back('{ch: 3'd0, edg: 1'b1, ts: ts_model});
        tick();
        TRIG_IN = '0; TRIG_EDGE_IN = '0;
        check("t5_post", 32'(STATE), 32'(S_POST));
        check("t5_ts_small", 32'(TRIG_TS < 8'd8), 32'd1);
        wait_state(S_DONE, 5, "t5_done");
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
